// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing defaults, test-pattern mode
// codes and the colour-bar table used by the built-in pattern generator.
package vga_pkg;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   typedef enum logic [1:0] {
      PAT_EXT   = 2'd0,
      PAT_BARS  = 2'd1,
      PAT_CHECK = 2'd2,
      PAT_WHITE = 2'd3
   } pat_mode_e;

   // {R,G,B} on/off masks, left to right: white, yellow, cyan, green,
   // magenta, red, blue, black
   localparam logic [2:0] BAR_MASK [8] = '{
      3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
   };

   function automatic logic [2:0] bar_mask(input logic [2:0] idx);
      return BAR_MASK[idx];
   endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Combinational built-in test pattern: colour for (h, v) in the given mode.
// Returns 0 in PAT_EXT; the external colour is selected downstream.
module vga_pattern_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned COLOR_W  = 4,
   parameter int unsigned CW       = 10
) (
   input  logic [CW-1:0]        h_i,
   input  logic [CW-1:0]        v_i,
   input  pat_mode_e            mode_i,
   output logic [3*COLOR_W-1:0] rgb_o
);

   localparam logic [CW-1:0] BAR_W = CW'(H_ACTIVE / 8);

   logic [CW-1:0] bar_idx;
   logic [2:0]    mask;
   logic          unused_v;

   assign unused_v = ^v_i;

   // Select the pattern colour for the current coordinate
   always_comb begin
      bar_idx = h_i / BAR_W;
      mask    = bar_mask(bar_idx[2:0]);
      rgb_o   = '0;
      case (mode_i)
         PAT_BARS:  rgb_o = {{COLOR_W{mask[2]}}, {COLOR_W{mask[1]}}, {COLOR_W{mask[0]}}};
         PAT_CHECK: rgb_o = (h_i[5] ^ v_i[5]) ? '1 : '0;
         PAT_WHITE: rgb_o = '1;
         default:   rgb_o = '0;
      endcase
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: h/v counters, a PIPE_LAT-deep delay line that
// matches the external pixel requester latency, and one output register
// so sync, DE, RGB and frame_start leave the block mutually aligned.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned COLOR_W  = 4,
   parameter int unsigned CW       = 10,
   parameter int unsigned PIPE_LAT = 2
) (
   input  logic                 CLKOUT,
   input  logic                 aclr_i,
   input  logic                 en,
   input  logic [1:0]           pattern_sel,
   input  logic [3*COLOR_W-1:0] csel,
   output logic [CW-1:0]        hcoord,
   output logic [CW-1:0]        vcoord,
   output logic                 req_active,
   output logic                 HSYNC,
   output logic                 VSYNC,
   output logic                 DE,
   output logic [COLOR_W-1:0]   RED,
   output logic [COLOR_W-1:0]   GREEN,
   output logic [COLOR_W-1:0]   BLUE,
   output logic                 frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

   typedef struct packed {
      logic                 act;
      logic                 hs;
      logic                 vs;
      logic                 start;
      pat_mode_e            mode;
      logic [3*COLOR_W-1:0] rgb;
   } stage_t;

   logic [CW-1:0]        h_q, h_d, v_q, v_d;
   pat_mode_e            mode_q, mode_d;
   logic                 frame_origin;
   logic [3*COLOR_W-1:0] pat_rgb;
   stage_t               raw_s, dly_s;

   logic                 hsync_q, hsync_d;
   logic                 vsync_q, vsync_d;
   logic                 de_q, de_d;
   logic                 fs_q, fs_d;
   logic [3*COLOR_W-1:0] rgb_q, rgb_d;

   // Counter advance/wrap and pattern-mode capture at the frame origin
   always_comb begin
      h_d          = h_q + 1'b1;
      v_d          = v_q;
      frame_origin = (h_q == '0) && (v_q == '0);
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end
      // New mode is used by pixel (0,0) itself, so a whole frame shares one mode
      mode_d = frame_origin ? pat_mode_e'(pattern_sel) : mode_q;
   end

   // Counter and mode registers
   always_ff @(posedge CLKOUT or posedge aclr_i) begin
      if (aclr_i) begin
         h_q    <= '0;
         v_q    <= '0;
         mode_q <= PAT_EXT;
      end else if (en) begin
         h_q    <= h_d;
         v_q    <= v_d;
         mode_q <= mode_d;
      end
   end

   vga_pattern_gen #(
      .H_ACTIVE (H_ACTIVE),
      .COLOR_W  (COLOR_W),
      .CW       (CW)
   ) u_pattern (
      .h_i    (h_q),
      .v_i    (v_q),
      .mode_i (mode_d),
      .rgb_o  (pat_rgb)
   );

   // Raw timing flags at the counter stage
   always_comb begin
      raw_s       = '0;
      raw_s.act   = (h_q < H_ACT) && (v_q < V_ACT);
      raw_s.hs    = (h_q >= HS_BEG) && (h_q < HS_END);
      raw_s.vs    = (v_q >= VS_BEG) && (v_q < VS_END);
      raw_s.start = frame_origin;
      raw_s.mode  = mode_d;
      raw_s.rgb   = pat_rgb;
   end

   generate
      if (PIPE_LAT == 0) begin : g_nodly
         assign dly_s = raw_s;
      end else begin : g_dly
         stage_t pipe_q [PIPE_LAT];

         // Delay line matching the external requester latency
         always_ff @(posedge CLKOUT or posedge aclr_i) begin
            if (aclr_i) begin
               for (int unsigned i = 0; i < PIPE_LAT; i++) pipe_q[i] <= '0;
            end else if (en) begin
               pipe_q[0] <= raw_s;
               for (int unsigned i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end

         assign dly_s = pipe_q[PIPE_LAT-1];
      end
   endgenerate

   // Output stage: sync polarity, blanking and colour source selection
   always_comb begin
      hsync_d = dly_s.hs ? HS_POL : ~HS_POL;
      vsync_d = dly_s.vs ? VS_POL : ~VS_POL;
      de_d    = dly_s.act;
      fs_d    = dly_s.start;
      rgb_d   = '0;
      if (dly_s.act) rgb_d = (dly_s.mode == PAT_EXT) ? csel : dly_s.rgb;
   end

   // Output register aligning sync, DE, colour and frame_start
   always_ff @(posedge CLKOUT or posedge aclr_i) begin
      if (aclr_i) begin
         hsync_q <= ~HS_POL;
         vsync_q <= ~VS_POL;
         de_q    <= 1'b0;
         fs_q    <= 1'b0;
         rgb_q   <= '0;
      end else if (en) begin
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         de_q    <= de_d;
         fs_q    <= fs_d;
         rgb_q   <= rgb_d;
      end
   end

   assign hcoord              = h_q;
   assign vcoord              = v_q;
   assign req_active          = raw_s.act;
   assign HSYNC               = hsync_q;
   assign VSYNC               = vsync_q;
   assign DE                  = de_q;
   assign frame_start         = fs_q;
   assign {RED, GREEN, BLUE}  = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced 96x49 raster
// (64 active + 8 FP + 16 sync + 8 BP; 40 active + 3 FP + 2 sync + 4 BP).
module tb_vga_timing_gen;

   localparam int HA  = 64;
   localparam int HT  = 96;
   localparam int VA  = 40;
   localparam int VT  = 49;
   localparam int FT  = HT * VT;
   localparam int LAT = 3;

   typedef struct packed {
      logic [9:0]  h;
      logic [9:0]  v;
      logic        ra;
      logic        hs;
      logic        vs;
      logic        de;
      logic [11:0] rgb;
      logic        fs;
   } ovec_t;

   logic        CLKOUT;
   logic        aclr_i;
   logic        en;
   logic [1:0]  pattern_sel;
   logic [11:0] csel;
   logic [9:0]  hcoord, vcoord;
   logic        req_active, HSYNC, VSYNC, DE, frame_start;
   logic [3:0]  RED, GREEN, BLUE;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          ncyc     = 0;
   logic [1:0]  frame_mode [16];
   logic [11:0] req0, req1;
   ovec_t       obs;

   vga_timing_gen #(
      .H_ACTIVE (64), .H_FP (8), .H_SYNC (16), .H_BP (8),
      .V_ACTIVE (40), .V_FP (3), .V_SYNC (2),  .V_BP (4),
      .HS_POL   (1'b0), .VS_POL (1'b0),
      .COLOR_W  (4), .CW (10), .PIPE_LAT (2)
   ) dut (
      .CLKOUT      (CLKOUT),
      .aclr_i      (aclr_i),
      .en          (en),
      .pattern_sel (pattern_sel),
      .csel        (csel),
      .hcoord      (hcoord),
      .vcoord      (vcoord),
      .req_active  (req_active),
      .HSYNC       (HSYNC),
      .VSYNC       (VSYNC),
      .DE          (DE),
      .RED         (RED),
      .GREEN       (GREEN),
      .BLUE        (BLUE),
      .frame_start (frame_start)
   );

   initial CLKOUT = 1'b0;
   always #5 CLKOUT = ~CLKOUT;

   always_comb obs = {hcoord, vcoord, req_active, HSYNC, VSYNC, DE, RED, GREEN, BLUE, frame_start};

   // External pixel requester: two enabled cycles of latency, FFF in h blanking
   function automatic logic [11:0] req_f(input logic [9:0] h, input logic [9:0] v);
      if (h >= 10'(HA)) return 12'hFFF;
      return {h[3:0], v[3:0], 4'hA};
   endfunction

   always @(posedge CLKOUT or posedge aclr_i) begin
      if (aclr_i) begin
         req0 <= '0;
         req1 <= '0;
      end else if (en) begin
         req0 <= req_f(hcoord, vcoord);
         req1 <= req0;
      end
   end
   assign csel = req1;

   function automatic logic [11:0] bar_rgb(input int idx);
      case (idx)
         0: return 12'hFFF;
         1: return 12'hFF0;
         2: return 12'h0FF;
         3: return 12'h0F0;
         4: return 12'hF0F;
         5: return 12'hF00;
         6: return 12'h00F;
         default: return 12'h000;
      endcase
   endfunction

   // Expected outputs in enabled cycle n after reset release
   function automatic ovec_t exp_at(input int n);
      ovec_t e;
      int h, v, k, kh, kv;
      h = n % HT;
      v = (n / HT) % VT;
      e.h   = 10'(h);
      e.v   = 10'(v);
      e.ra  = (h < HA) && (v < VA);
      e.hs  = 1'b1;
      e.vs  = 1'b1;
      e.de  = 1'b0;
      e.rgb = 12'h000;
      e.fs  = 1'b0;
      k = n - LAT;
      if (k >= 0) begin
         kh = k % HT;
         kv = (k / HT) % VT;
         e.hs = !(kh >= 72 && kh < 88);
         e.vs = !(kv >= 43 && kv < 45);
         e.de = (kh < HA) && (kv < VA);
         e.fs = (kh == 0) && (kv == 0);
         if (e.de) begin
            case (frame_mode[k / FT])
               2'd0: e.rgb = {4'(kh), 4'(kv), 4'hA};
               2'd1: e.rgb = bar_rgb(kh / 8);
               2'd2: e.rgb = (((kh ^ kv) & 32) != 0) ? 12'hFFF : 12'h000;
               default: e.rgb = 12'hFFF;
            endcase
         end
      end
      return e;
   endfunction

   task automatic tick();
      if (en && (ncyc % FT) == 0) frame_mode[ncyc / FT] = pattern_sel;
      @(posedge CLKOUT);
      #1;
      if (en) ncyc++;
   endtask

   task automatic test_reset();
      ovec_t e;
      aclr_i = 1'b1;
      en = 1'b1;
      pattern_sel = 2'd0;
      for (int i = 0; i < 16; i++) frame_mode[i] = 2'd0;
      repeat (10) @(posedge CLKOUT);
      #1;
      n_checks++;
      if ({hcoord, vcoord} !== 20'd0) begin
         n_fail++; $display("FAIL reset_coord got %h/%h expected 0/0", hcoord, vcoord);
      end
      n_checks++;
      if ({HSYNC, VSYNC, DE, RED, GREEN, BLUE, frame_start} !== {1'b1, 1'b1, 1'b0, 12'h000, 1'b0}) begin
         n_fail++; $display("FAIL reset_outputs got hs=%b vs=%b de=%b rgb=%h fs=%b expected 1 1 0 000 0",
                            HSYNC, VSYNC, DE, {RED, GREEN, BLUE}, frame_start);
      end
      aclr_i = 1'b0;
      ncyc = 0;
      e = exp_at(0);
      n_checks++;
      if (obs !== e) begin
         n_fail++; $display("FAIL release_first n=%0d got %h expected %h", ncyc, obs, e);
      end
      repeat (2) begin
         tick();
         n_checks++;
         if ({hcoord, HSYNC, VSYNC, DE, RED, GREEN, BLUE, frame_start} !==
             {10'(ncyc), 1'b1, 1'b1, 1'b0, 12'h000, 1'b0}) begin
            n_fail++; $display("FAIL latency_idle n=%0d got h=%0d hs=%b de=%b rgb=%h fs=%b expected h=%0d 1 0 000 0",
                               ncyc, hcoord, HSYNC, DE, {RED, GREEN, BLUE}, frame_start, ncyc);
         end
      end
   endtask

   task automatic test_line();
      ovec_t e;
      int hs_low = 0, de_hi = 0, first_low = -1, hc72 = -1;
      repeat (HT) begin
         tick();
         e = exp_at(ncyc);
         n_checks++;
         if (obs !== e) begin
            n_fail++; $display("FAIL line n=%0d got %h expected %h", ncyc, obs, e);
         end
         if (ncyc == 3) begin
            n_checks++;
            if ({DE, frame_start, RED, GREEN, BLUE} !== {1'b1, 1'b1, 12'h00A}) begin
               n_fail++; $display("FAIL first_pixel got de=%b fs=%b rgb=%h expected 1 1 00a",
                                  DE, frame_start, {RED, GREEN, BLUE});
            end
         end
         if (!HSYNC) hs_low++;
         if (!HSYNC && first_low < 0) first_low = ncyc;
         if (DE) de_hi++;
         if (hcoord == 10'd72 && hc72 < 0) hc72 = ncyc;
      end
      n_checks++;
      if (hs_low != 16) begin
         n_fail++; $display("FAIL hsync_width got %0d expected 16", hs_low);
      end
      n_checks++;
      if (first_low - hc72 != 3) begin
         n_fail++; $display("FAIL hsync_delay got %0d expected 3", first_low - hc72);
      end
      n_checks++;
      if (de_hi != 64) begin
         n_fail++; $display("FAIL de_width got %0d expected 64", de_hi);
      end
   endtask

   task automatic test_frame_wrap();
      ovec_t e;
      int vs_low = 0, fs_cnt = 0, fs_n = -1;
      logic [19:0] pre = '1, post = '1;
      while (ncyc < FT + 5) begin
         tick();
         e = exp_at(ncyc);
         n_checks++;
         if (obs !== e) begin
            n_fail++; $display("FAIL frame n=%0d got %h expected %h", ncyc, obs, e);
         end
         if (ncyc <= FT + 2 && !VSYNC) vs_low++;
         if (frame_start) begin fs_cnt++; fs_n = ncyc; end
         if (ncyc == FT - 1) pre = {hcoord, vcoord};
         if (ncyc == FT) post = {hcoord, vcoord};
      end
      n_checks++;
      if (pre !== {10'd95, 10'd48}) begin
         n_fail++; $display("FAIL last_coord got %0d,%0d expected 95,48", pre[19:10], pre[9:0]);
      end
      n_checks++;
      if (post !== 20'd0) begin
         n_fail++; $display("FAIL wrap_coord got %0d,%0d expected 0,0", post[19:10], post[9:0]);
      end
      n_checks++;
      if (fs_cnt != 1 || fs_n != FT + 3) begin
         n_fail++; $display("FAIL frame_start got count=%0d at=%0d expected 1 at %0d", fs_cnt, fs_n, FT + 3);
      end
      n_checks++;
      if (vs_low != 2 * HT) begin
         n_fail++; $display("FAIL vsync_width got %0d expected %0d", vs_low, 2 * HT);
      end
   endtask

   task automatic test_pattern_switch();
      ovec_t e;
      int budget = 11 * HT + 10;
      while (vcoord != 10'd10 && budget > 0) begin
         tick();
         budget--;
         e = exp_at(ncyc);
         n_checks++;
         if (obs !== e) begin
            n_fail++; $display("FAIL pre_switch n=%0d got %h expected %h", ncyc, obs, e);
         end
      end
      n_checks++;
      if (vcoord != 10'd10) begin
         n_fail++; $display("FAIL wait_v10 got v=%0d expected 10", vcoord);
      end
      pattern_sel = 2'd1;
      while (ncyc < 2 * FT + 2 * HT + LAT) begin
         tick();
         e = exp_at(ncyc);
         n_checks++;
         if (obs !== e) begin
            n_fail++; $display("FAIL switch n=%0d got %h expected %h", ncyc, obs, e);
         end
         if (ncyc == FT + 20 * HT + 8 + LAT) begin
            n_checks++;
            if ({RED, GREEN, BLUE} !== 12'h84A) begin
               n_fail++; $display("FAIL ext_held got %h expected 84a", {RED, GREEN, BLUE});
            end
         end
         if (ncyc == 2 * FT + LAT) begin
            n_checks++;
            if ({RED, GREEN, BLUE} !== 12'hFFF) begin
               n_fail++; $display("FAIL bar_white got %h expected fff", {RED, GREEN, BLUE});
            end
         end
         if (ncyc == 2 * FT + 8 + LAT) begin
            n_checks++;
            if ({RED, GREEN, BLUE} !== 12'hFF0) begin
               n_fail++; $display("FAIL bar_yellow got %h expected ff0", {RED, GREEN, BLUE});
            end
         end
         if (ncyc == 2 * FT + 16 + LAT) begin
            n_checks++;
            if ({RED, GREEN, BLUE} !== 12'h0FF) begin
               n_fail++; $display("FAIL bar_cyan got %h expected 0ff", {RED, GREEN, BLUE});
            end
         end
         if (ncyc == 2 * FT + 56 + LAT) begin
            n_checks++;
            if ({DE, RED, GREEN, BLUE} !== {1'b1, 12'h000}) begin
               n_fail++; $display("FAIL bar_black got de=%b rgb=%h expected 1 000", DE, {RED, GREEN, BLUE});
            end
         end
      end
   endtask

   task automatic test_checker();
      ovec_t e;
      pattern_sel = 2'd2;
      while (ncyc < 3 * FT + 34 * HT) begin
         tick();
         e = exp_at(ncyc);
         n_checks++;
         if (obs !== e) begin
            n_fail++; $display("FAIL checker n=%0d got %h expected %h", ncyc, obs, e);
         end
         if (ncyc == 2 * FT + 5 * HT + 8 + LAT) begin
            n_checks++;
            if ({RED, GREEN, BLUE} !== 12'hFF0) begin
               n_fail++; $display("FAIL bars_kept got %h expected ff0", {RED, GREEN, BLUE});
            end
         end
         if (ncyc == 3 * FT + HT + 40 + LAT) begin
            n_checks++;
            if ({RED, GREEN, BLUE} !== 12'hFFF) begin
               n_fail++; $display("FAIL check_h40v1 got %h expected fff", {RED, GREEN, BLUE});
            end
         end
         if (ncyc == 3 * FT + 33 * HT + 40 + LAT) begin
            n_checks++;
            if ({DE, RED, GREEN, BLUE} !== {1'b1, 12'h000}) begin
               n_fail++; $display("FAIL check_h40v33 got de=%b rgb=%h expected 1 000", DE, {RED, GREEN, BLUE});
            end
         end
         if (ncyc == 3 * FT + 33 * HT + 8 + LAT) begin
            n_checks++;
            if ({RED, GREEN, BLUE} !== 12'hFFF) begin
               n_fail++; $display("FAIL check_h8v33 got %h expected fff", {RED, GREEN, BLUE});
            end
         end
      end
   endtask

   task automatic test_en_toggle();
      ovec_t e;
      int start_n = ncyc;
      logic [9:0] last_h;
      for (int i = 0; i < 200; i++) begin
         last_h = hcoord;
         en = (i % 2 == 0);
         tick();
         e = exp_at(ncyc);
         n_checks++;
         if (obs !== e) begin
            n_fail++; $display("FAIL en_toggle i=%0d n=%0d got %h expected %h", i, ncyc, obs, e);
         end
         if (!en) begin
            n_checks++;
            if (hcoord !== last_h) begin
               n_fail++; $display("FAIL en_hold i=%0d got h=%0d expected %0d", i, hcoord, last_h);
            end
         end
      end
      en = 1'b1;
      n_checks++;
      if (ncyc - start_n != 100) begin
         n_fail++; $display("FAIL en_rate got %0d steps expected 100", ncyc - start_n);
      end
   endtask

   task automatic test_reset_midline();
      ovec_t e;
      int budget = 2 * HT;
      while (hcoord != 10'd30 && budget > 0) begin
         tick();
         budget--;
         e = exp_at(ncyc);
         n_checks++;
         if (obs !== e) begin
            n_fail++; $display("FAIL pre_reset n=%0d got %h expected %h", ncyc, obs, e);
         end
      end
      n_checks++;
      if (hcoord != 10'd30) begin
         n_fail++; $display("FAIL wait_h30 got h=%0d expected 30", hcoord);
      end
      #2;
      aclr_i = 1'b1;
      #1;
      n_checks++;
      if ({hcoord, vcoord, HSYNC, VSYNC, DE, RED, GREEN, BLUE, frame_start} !==
          {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0}) begin
         n_fail++; $display("FAIL async_reset got h=%0d v=%0d hs=%b vs=%b de=%b rgb=%h fs=%b expected 0 0 1 1 0 000 0",
                            hcoord, vcoord, HSYNC, VSYNC, DE, {RED, GREEN, BLUE}, frame_start);
      end
      repeat (2) @(posedge CLKOUT);
      #1;
      pattern_sel = 2'd0;
      for (int i = 0; i < 16; i++) frame_mode[i] = 2'd0;
      aclr_i = 1'b0;
      ncyc = 0;
      repeat (5) begin
         tick();
         e = exp_at(ncyc);
         n_checks++;
         if (obs !== e) begin
            n_fail++; $display("FAIL restart n=%0d got %h expected %h", ncyc, obs, e);
         end
      end
      n_checks++;
      if (hcoord !== 10'd5) begin
         n_fail++; $display("FAIL restart_count got h=%0d expected 5", hcoord);
      end
   endtask

   initial begin
      aclr_i = 1'b1;
      en = 1'b1;
      pattern_sel = 2'd0;
      test_reset();
      test_line();
      test_frame_wrap();
      test_pattern_switch();
      test_checker();
      test_en_toggle();
      test_reset_midline();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog time limit reached at n=%0d", ncyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster generator. It produces horizontal and vertical counters, sync, data-enable and RGB for any resolution.
- Colour source is an external pixel requester with a configurable fetch latency, or a built-in test pattern.
- Sync, DE and RGB leave the block mutually aligned.
- Sits between the game/scene renderer (which drives csel from hcoord/vcoord) and the board VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, HSYNC active level
VS_POL, 0, VSYNC active level
COLOR_W, 4, bits per colour channel
CW, 10, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
PIPE_LAT, 2, cycles from hcoord/vcoord valid to matching csel valid (>=0)

Ports:
CLKOUT  in  1  pixel clock
aclr_i  in  1  reset, asynchronous, active-high
en  in  1  pixel-enable; all registers advance only when 1
pattern_sel  in  2  0=external csel, 1=colour bars, 2=checkerboard, 3=solid white
csel  in  3*COLOR_W  {R,G,B} for coordinate issued PIPE_LAT enabled cycles earlier
hcoord  out  CW  current horizontal count (request address)
vcoord  out  CW  current vertical count (request address)
req_active  out  1  hcoord/vcoord lie in the visible region
HSYNC  out  1  aligned horizontal sync
VSYNC  out  1  aligned vertical sync
DE  out  1  aligned data enable
RED/GREEN/BLUE  out  COLOR_W each  aligned colour
frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counter wrap:
  - h counts 0..H_TOTAL-1, then returns to 0.
  - v increments when h wraps and returns to 0 after V_TOTAL-1.
  - No out-of-range value is ever emitted.
- Raw timing at counter stage:
  - active = (h<H_ACTIVE)&&(v<V_ACTIVE).
  - hs_act when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_act when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491).
- Output latency:
  - hcoord/vcoord/req_active are the counter registers (latency 0).
  - active, hs_act, vs_act, start flag (h==0&&v==0) and pattern colour pass through a PIPE_LAT-deep enabled shift register.
  - A final output register captures them together with csel.
  - Total latency from coordinate to HSYNC/VSYNC/DE/RGB/frame_start is PIPE_LAT+1 enabled cycles.
- Output sync levels: HSYNC = hs_act ? HS_POL : ~HS_POL; VSYNC likewise with VS_POL.
- RGB:
  - When the delayed active flag is 0, RGB = 0 regardless of csel.
  - Otherwise RGB = csel (mode 0) or the delayed pattern colour (modes 1-3).
- Pattern modes:
  - Colour bars: 8 equal bars of H_ACTIVE/8 pixels, in order white, yellow, cyan, green, magenta, red, blue, black. Full scale = all ones. H_ACTIVE must be divisible by 8.
  - Checkerboard: white when h[5]^v[5], else black.
- pattern_sel is latched into the mode register only on an enabled cycle where h==0&&v==0. A mid-frame change takes effect at the next frame.
- en=0: every register holds, outputs frozen; the requester must hold its own pipeline too. en toggling changes rate only; no count is skipped or repeated.
- Reset (asynchronous, any time, including mid-line):
  - h=v=0; pipeline cleared; mode=0.
  - HSYNC=~HS_POL, VSYNC=~VS_POL; DE=0; RGB=0; frame_start=0.
  - First enabled cycle after release presents (0,0).
- frame_start is high for exactly one enabled cycle per frame.

Decomposition:
- Shared package vga_pkg holds:
  - 640x480@60 timing defaults;
  - pattern_sel codes (PAT_EXT, PAT_BARS, PAT_CHECK, PAT_WHITE);
  - 8-entry colour-bar table (3-bit RGB masks expanded to COLOR_W).
- One sub-module vga_pattern_gen: combinational colour from (h, v, mode). The top module owns the counters, delay line and output register.

Test Plan:
- Reset held 10 cycles then released with en=1 -> outputs at reset values during reset; hcoord=0,vcoord=0 on first cycle; HSYNC=1,VSYNC=1,DE=0,RGB=0 until latency expires.
- Free run one line, PIPE_LAT=2 -> HSYNC low exactly 96 cycles, first low 3 cycles after hcoord=656; DE high 640 cycles per visible line.
- Frame wrap -> hcoord 799,vcoord 524 followed by 0,0; frame_start pulses once, 3 cycles later; VSYNC low for exactly 2 lines (490,491).
- Mode 0, csel driven as {h[3:0],v[3:0],4'hA} delayed 2 cycles -> RGB matches the coordinate issued 3 cycles earlier; csel=FFF at h=640..799 -> RGB=000.
- pattern_sel 0->1 at vcoord=100 -> RGB stays external until next frame; then h=80 gives yellow (F,F,0) and h=560 gives black.
- en toggled 1,0,1,0 -> counter sequence identical to free run at half rate; reset asserted mid-line at h=300 -> immediate defaults, restart at (0,0).
